// File: rtl/hwpe_stream_job_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// hwpe_stream_job_sequencer_pkg
// Shared types for the HWPE stream job sequencer and the source/sink ports
// it drives.
//   ctrl_addressgen_t  : per-stream address generator configuration
//   flags_sourcesink_t : status reported by a source/sink (ready_start, done)
//   ctrl_sourcesink_t  : control sent to a source/sink (req_start + config)
//   job_seq_state_t    : job sequencer FSM states
// ---------------------------------------------------------------------------
package hwpe_stream_job_sequencer_pkg;

  typedef struct packed {
    logic [31:0] base_addr;
    logic [31:0] trans_size;
    logic [15:0] line_stride;
    logic [15:0] line_length;
  } ctrl_addressgen_t;

  typedef struct packed {
    logic ready_start;
    logic done;
  } flags_sourcesink_t;

  typedef struct packed {
    logic             req_start;
    ctrl_addressgen_t addressgen_ctrl;
  } ctrl_sourcesink_t;

  typedef enum logic [2:0] {
    JOB_IDLE,
    JOB_WAIT_READY,
    JOB_START,
    JOB_RUN,
    JOB_DONE
  } job_seq_state_t;

endpackage

// File: rtl/hwpe_stream_job_sequencer_done_collector.sv
// ---------------------------------------------------------------------------
// hwpe_stream_done_collector
// Sticky per-stream done bits for one job.
//   clk_i      in  clock
//   rst_i      in  synchronous reset, active-high
//   clear_i    in  clear all done bits (new job accepted)
//   enable_i   in  allow done_i to set bits this cycle
//   mask_i     in  NB_STREAM  streams taking part in the job
//   done_i     in  NB_STREAM  per-stream done flags
//   all_done_o out every masked stream is done (1 when mask_i is 0)
// ---------------------------------------------------------------------------
module hwpe_stream_done_collector #(
  parameter int unsigned NB_STREAM = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 enable_i,
  input  logic [NB_STREAM-1:0] mask_i,
  input  logic [NB_STREAM-1:0] done_i,
  output logic                 all_done_o
);

  logic [NB_STREAM-1:0] done_q;
  logic [NB_STREAM-1:0] set_now;

  assign set_now = enable_i ? (done_i & mask_i) : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_q <= '0;
    end else if (clear_i) begin
      done_q <= '0;
    end else begin
      done_q <= done_q | set_now;
    end
  end

  // Includes this cycle's done flags so the sequencer can leave RUN on the
  // cycle right after the last done arrives.
  assign all_done_o = &(~mask_i | done_q | set_now);

endmodule

// File: rtl/hwpe_stream_job_sequencer.sv
// ---------------------------------------------------------------------------
// hwpe_stream_job_sequencer
// Job-level controller for a group of HWPE stream sources/sinks: latches the
// per-stream config on start, waits for all enabled streams to be ready,
// issues one req_start pulse, collects done flags and reports completion.
//   clk_i        in  clock
//   rst_i        in  synchronous reset, active-high
//   start_i      in  job start request (accepted only in IDLE)
//   abort_i      in  job abort request (ignored in IDLE)
//   stream_en_i  in  NB_STREAM per-stream enable mask (latched on start)
//   cfg_i        in  NB_STREAM x ctrl_addressgen_t (latched on start)
//   flags_i      in  NB_STREAM x flags_sourcesink_t
//   ctrl_o       out NB_STREAM x ctrl_sourcesink_t
//   busy_o       out high outside IDLE
//   done_o       out 1-cycle completion pulse
//   aborted_o    out 1-cycle pulse on abort or watchdog expiry
//   timeout_o    out sticky watchdog flag, cleared on next accepted start
//   cycles_o     out saturating RUN cycle count of current/last job
//
// state          | meaning
// JOB_IDLE       | no job; waiting for start_i
// JOB_WAIT_READY | config latched; waiting for ready_start on enabled streams
// JOB_START      | single cycle; req_start to every enabled stream
// JOB_RUN        | counting cycles; collecting done flags
// JOB_DONE       | single cycle; done_o pulse
// ---------------------------------------------------------------------------
module hwpe_stream_job_sequencer
  import hwpe_stream_job_sequencer_pkg::*;
#(
  parameter int unsigned NB_STREAM      = 2,
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  start_i,
  input  logic                                  abort_i,
  input  logic              [NB_STREAM-1:0]     stream_en_i,
  input  ctrl_addressgen_t  [NB_STREAM-1:0]     cfg_i,
  input  flags_sourcesink_t [NB_STREAM-1:0]     flags_i,
  output ctrl_sourcesink_t  [NB_STREAM-1:0]     ctrl_o,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic                                  aborted_o,
  output logic                                  timeout_o,
  output logic              [CNT_WIDTH-1:0]     cycles_o
);

  localparam bit                   WDOG_EN     = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);

  job_seq_state_t                   state_q, state_d;
  logic             [NB_STREAM-1:0] en_q;
  ctrl_addressgen_t [NB_STREAM-1:0] cfg_q;
  logic             [CNT_WIDTH-1:0] cycles_q;
  logic                             timeout_q;

  logic [NB_STREAM-1:0] ready_vec;
  logic [NB_STREAM-1:0] done_vec;
  logic                 all_ready;
  logic                 all_done;
  logic                 start_acc;
  logic                 timeout_hit;
  logic                 abort_any;
  logic                 collect_en;

  always_comb begin
    ready_vec = '0;
    done_vec  = '0;
    for (int i = 0; i < NB_STREAM; i++) begin
      ready_vec[i] = flags_i[i].ready_start;
      done_vec[i]  = flags_i[i].done;
    end
  end

  assign all_ready   = &(ready_vec | ~en_q);
  assign start_acc   = (state_q == JOB_IDLE) && start_i;
  assign timeout_hit = WDOG_EN && (state_q == JOB_RUN) && (cycles_q == TIMEOUT_VAL);
  assign abort_any   = (abort_i && (state_q != JOB_IDLE)) || timeout_hit;
  assign collect_en  = (state_q == JOB_START) || (state_q == JOB_RUN);

  hwpe_stream_done_collector #(
    .NB_STREAM (NB_STREAM)
  ) i_done_collector (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (start_acc),
    .enable_i   (collect_en),
    .mask_i     (en_q),
    .done_i     (done_vec),
    .all_done_o (all_done)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= JOB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (abort_any) begin
      state_d = JOB_IDLE;
    end else begin
      case (state_q)
        JOB_IDLE:       if (start_i) state_d = JOB_WAIT_READY;
        JOB_WAIT_READY: begin
          if (en_q == '0) begin
            state_d = JOB_DONE;
          end else if (all_ready) begin
            state_d = JOB_START;
          end
        end
        JOB_START:      state_d = JOB_RUN;
        JOB_RUN:        if (all_done) state_d = JOB_DONE;
        JOB_DONE:       state_d = JOB_IDLE;
        default:        state_d = JOB_IDLE;
      endcase
    end
  end

  // Outputs; an abort in START or DONE suppresses req_start / done_o that cycle
  always_comb begin
    ctrl_o    = '0;
    busy_o    = (state_q != JOB_IDLE);
    done_o    = (state_q == JOB_DONE) && !abort_i;
    aborted_o = abort_any;
    timeout_o = timeout_q || timeout_hit;
    for (int i = 0; i < NB_STREAM; i++) begin
      ctrl_o[i].req_start       = (state_q == JOB_START) && !abort_i && en_q[i];
      ctrl_o[i].addressgen_ctrl = cfg_q[i];
    end
  end

  // Job datapath: latched config, run counter, sticky watchdog flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q      <= '0;
      cfg_q     <= '0;
      cycles_q  <= '0;
      timeout_q <= 1'b0;
    end else if (start_acc) begin
      en_q      <= stream_en_i;
      cfg_q     <= cfg_i;
      cycles_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state_q == JOB_RUN) && !abort_any && (cycles_q != '1)) begin
        cycles_q <= cycles_q + 1'b1;
      end
      if (timeout_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign cycles_o = cycles_q;

endmodule
